irq_pending_ctrl: RTL

//   Interrupt front-end that sits directly upstream of the 8-to-3 priority encoder (pencode).
//   - Captures rising edges on N request lines into sticky pending bits.
//   - Drives the masked pending vector into the encoder.
//   - Latches the encoder's index and presents it to the consumer over a valid/ack handshake.
//   - Clears the serviced bit on ack.
//   - Flags events lost because the line was already pending.

---
 rtl/irq_pending_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: rising-edge capture into sticky pending bits,
// masked feed to an external priority encoder, valid/ack presentation.
module irq_pending_ctrl #(
   parameter int N   = 8,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   irq_in,
   input  logic [N-1:0]   mask,
   output logic [N-1:0]   pend_o,
   input  logic [IDW-1:0] sel_id,
   output logic           irq_valid,
   output logic [IDW-1:0] irq_id,
   input  logic           irq_ack,
   output logic [N-1:0]   lost,
   input  logic           lost_clr
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] HOLDOFF = 2'd2;

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [1:0]   state;
   logic [N-1:0] prev;
   logic [N-1:0] pending;

   logic         ack_fire;
   logic [N-1:0] rise;
   logic [N-1:0] clr_vec;
   logic [N-1:0] pending_nxt;
   logic [N-1:0] lost_set;
   logic [N-1:0] lost_nxt;

   assign pend_o = pending & mask;

   // A same-cycle rise beats the ack clear, so the new event survives.
   always_comb begin
      ack_fire    = (state == PRESENT) && irq_ack;
      rise        = irq_in & ~prev;
      clr_vec     = ack_fire ? (ONE << irq_id) : '0;
      pending_nxt = (pending & ~clr_vec) | rise;
      lost_set    = rise & pending & ~clr_vec;
      lost_nxt    = lost_clr ? '0 : (lost | lost_set);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev    <= irq_in;
         pending <= '0;
         lost    <= '0;
      end else begin
         prev    <= irq_in;
         pending <= pending_nxt;
         lost    <= lost_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|pend_o) begin
                  irq_id    <= sel_id;
                  irq_valid <= 1'b1;
                  state     <= PRESENT;
               end
            end
            PRESENT: begin
               if (irq_ack) begin
                  irq_valid <= 1'b0;
                  state     <= HOLDOFF;
               end
            end
            HOLDOFF: begin
               // Lets pend_o and the encoder output settle after the clear.
               state <= IDLE;
            end
            default: begin
               irq_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
